pe_os_mac: RTL and testbench
============================

# pe_os_mac

Parametrised output-stationary processing element for the systolic array: a signed fixed-point multiply-accumulate cell that forwards operands east/south with valid tags, accumulates a dot product of run-time length delimited by a `last` tag, and offloads finished results through a column drain shift chain. It supersedes the fixed 16-bit PE by generalising data, fraction and accumulator widths. It adds operand valid tracking, a tile state machine, rounding/saturation and result draining, so back-to-back tiles stream without a global reset.

## Interface
- `DATA_W`, 16, operand/result width, signed two's complement
- `FRAC_W`, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W); 1 ≤ FRAC_W < DATA_W
- `ACC_W`, 40, accumulator width; must be ≥ 2*DATA_W
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `en` in 1: global enable; when low every register holds (reset excepted)
- `clr` in 1: abort/clear current accumulation
- `A`, `B` in DATA_W: west / north operands
- `a_vld`, `b_vld` in 1: operand valid tags
- `a_last` in 1: marks final operand pair of a tile (qualified by `a_vld`)
- `A_out`, `B_out` out DATA_W: registered forwarded operands
- `a_vld_out`, `b_vld_out`, `a_last_out` out 1: registered forwarded tags
- `c_shift` in 1: drain chain shift strobe
- `c_in` in DATA_W, `c_vld_in` in 1: drain input from the PE above
- `C_out` out DATA_W, `c_vld` out 1: result register and its valid bit
- `busy` out 1: state == ACC
- `err` out 1: sticky; result collision or saturation event

## Operation
- Reset: acc, all output registers, state = IDLE, `c_vld`=0, `err`=0.
- `en`=0: nothing updates; all actions below are qualified by `en`=1.
- Forwarding every enabled cycle: `A_out`<=A, `B_out`<=B, tags likewise, irrespective of state.
- MAC fires when `a_vld & b_vld`; product = signed A*B (2*DATA_W), sign-extended to ACC_W.
- States:
  - IDLE: acc=0. MAC → acc<=product; go to ACC, or DONE if `a_last`.
  - ACC: MAC → acc<=acc+product (ACC_W wrap); `a_last` → DONE.
  - DONE: result written the cycle of entry. MAC → acc<=product (fresh tile); go to ACC, or stay DONE if `a_last`. No MAC → IDLE.
- Finishing MAC writes the result register: `C_out` <= fmt(acc_next), `c_vld`<=1.
- fmt: r = (acc_next + 2^(FRAC_W-1)) >>> FRAC_W (round half up), reduced to DATA_W per Configuration.
- Only one of a_vld/b_vld high: no MAC, state unchanged.
- `clr`: acc<=0, state<=IDLE; overrides a same-cycle MAC (no result write); result register untouched.
- Drain: `c_shift` → `C_out`<=c_in, `c_vld`<=c_vld_in (column shifts downward; top PE ties c_vld_in=0).
- `c_shift` and result write in the same cycle: result write wins, c_in dropped, `err`<=1.
- `err` clears only on reset.

## Timing
- Operand/tag forward latency: 1 cycle.
- Result latency: `C_out`/`c_vld` valid the cycle after the edge that samples the `a_last` MAC.
- Back-to-back tiles: new pair may arrive the cycle right after `a_last`; zero bubble.
- Drain: one PE per `c_shift` cycle; N-row column drains in N enabled shifts.
- Mid-operation `rst`: all state cleared immediately (async), outputs 0 without waiting for a clock.

## Configuration
- `PE_SAT_EN` defined: r clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; a clamp sets `err`.
- Undefined: r truncated to low DATA_W bits (wrap); no saturation logic and no `err` from overflow (collision still sets `err`).

## Test plan
- Q8.8: A=0x0180,B=0x0200 then A=0x0043,B=0x00CA with `a_last` → `C_out`=0x0335, `c_vld`=1 one cycle later.
- A=0xFF00 (-1.0), B=0x0200, `a_last` → `C_out`=0xFE00; `A_out`=0xFF00 one cycle after input.
- A=B=0x7F00, `a_last`: with `PE_SAT_EN` → 0x7FFF, `err`=1; without → 0x0100, `err`=0.
- Two tiles back-to-back (1.5*2.0, then 1.0*1.0 no gap) → 0x0300 then 0x0100; `en` low mid-tile freezes acc and outputs.
- `c_shift` with c_in=0x1234,c_vld_in=1 → `C_out`=0x1234; `c_shift` concurrent with `a_last` MAC → new result kept, `err`=1.
- `clr` same cycle as MAC, then `rst` asserted mid-ACC between edges → no result write; all outputs 0 immediately.

Source files
------------

// File: rtl/pe_os_mac.sv
// Output-stationary signed fixed-point MAC cell with operand forwarding, tile FSM and drain chain.
// Optional saturation of the formatted result is enabled by defining PE_SAT_EN.
module pe_os_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              a_vld,
    input  logic              b_vld,
    input  logic              a_last,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    output logic              a_vld_out,
    output logic              b_vld_out,
    output logic              a_last_out,
    input  logic              c_shift,
    input  logic [DATA_W-1:0] c_in,
    input  logic              c_vld_in,
    output logic [DATA_W-1:0] C_out,
    output logic              c_vld,
    output logic              busy,
    output logic              err
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_W - 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    rnd_shift;
    logic [DATA_W-1:0]        res;
    logic                     sat_evt;
    logic                     mac;
    logic                     res_wr;

    assign mac         = a_vld & b_vld;
    assign product     = $signed(A) * $signed(B);
    assign product_ext = ACC_W'(product);

    // Round half up on one extra bit so the rounding add cannot wrap.
    assign rnd_sum   = $signed({acc_next[ACC_W-1], acc_next}) + $signed(HALF);
    assign rnd_shift = rnd_sum >>> FRAC_W;

`ifdef PE_SAT_EN
    logic sat_hi;
    logic sat_lo;
    assign sat_hi  = ~rnd_shift[ACC_W] & (|rnd_shift[ACC_W-1:DATA_W-1]);
    assign sat_lo  = rnd_shift[ACC_W] & ~(&rnd_shift[ACC_W-1:DATA_W-1]);
    assign sat_evt = sat_hi | sat_lo;
    always_comb begin
        res = rnd_shift[DATA_W-1:0];
        if (sat_hi)
            res = {1'b0, {(DATA_W-1){1'b1}}};
        else if (sat_lo)
            res = {1'b1, {(DATA_W-1){1'b0}}};
    end
`else
    logic unused_bits;
    assign sat_evt     = 1'b0;
    assign res         = rnd_shift[DATA_W-1:0];
    assign unused_bits = ^rnd_shift[ACC_W:DATA_W];
`endif

    // State register and all datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            A_out      <= '0;
            B_out      <= '0;
            a_vld_out  <= 1'b0;
            b_vld_out  <= 1'b0;
            a_last_out <= 1'b0;
            C_out      <= '0;
            c_vld      <= 1'b0;
            err        <= 1'b0;
        end else if (en) begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            A_out      <= A;
            B_out      <= B;
            a_vld_out  <= a_vld;
            b_vld_out  <= b_vld;
            a_last_out <= a_last;
            if (res_wr) begin
                C_out <= res;
                c_vld <= 1'b1;
            end else if (c_shift) begin
                C_out <= c_in;
                c_vld <= c_vld_in;
            end
            if (res_wr && (c_shift || sat_evt))
                err <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (mac) state_next = a_last ? DONE : ACC;
                ACC:  if (mac && a_last) state_next = DONE;
                DONE: begin
                    if (mac)
                        state_next = a_last ? DONE : ACC;
                    else
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output / datapath control; leaving DONE without a MAC returns acc to zero for IDLE.
    always_comb begin
        acc_next = acc_reg;
        res_wr   = 1'b0;
        if (clr) begin
            acc_next = '0;
        end else begin
            case (state_reg)
                IDLE:    acc_next = mac ? product_ext : '0;
                ACC:     if (mac) acc_next = acc_reg + product_ext;
                DONE:    acc_next = mac ? product_ext : '0;
                default: acc_next = '0;
            endcase
            res_wr = mac & a_last;
        end
    end

    assign busy = (state_reg == ACC);

endmodule

// File: tb/tb_pe_os_mac.sv
// Self-checking bench for pe_os_mac: directed steps then random traffic against a tile-level model.
module tb_pe_os_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, clr;
    logic [15:0] A, B;
    logic        a_vld, b_vld, a_last;
    logic [15:0] A_out, B_out;
    logic        a_vld_out, b_vld_out, a_last_out;
    logic        c_shift;
    logic [15:0] c_in;
    logic        c_vld_in;
    logic [15:0] C_out;
    logic        c_vld, busy, err;

    int checks = 0;
    int errors = 0;

    // Tile-level reference state
    longint      m_sum;
    bit          m_in;
    logic [15:0] m_c, m_aout, m_bout;
    bit          m_cv, m_err, m_av, m_bv, m_al;

    pe_os_mac dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .A(A), .B(B), .a_vld(a_vld), .b_vld(b_vld), .a_last(a_last),
        .A_out(A_out), .B_out(B_out), .a_vld_out(a_vld_out), .b_vld_out(b_vld_out),
        .a_last_out(a_last_out), .c_shift(c_shift), .c_in(c_in), .c_vld_in(c_vld_in),
        .C_out(C_out), .c_vld(c_vld), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] fmt(input longint s);
        longint r;
        r = (s + 128) >>> 8;
`ifdef PE_SAT_EN
        if (r > 32767)  return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, r[15:0]};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".C_out"}, C_out, m_c);
        check({tag, ".c_vld"}, c_vld, m_cv);
        check({tag, ".err"}, err, m_err);
        check({tag, ".busy"}, busy, m_in);
        check({tag, ".A_out"}, A_out, m_aout);
        check({tag, ".B_out"}, B_out, m_bout);
        check({tag, ".a_vld_out"}, a_vld_out, m_av);
        check({tag, ".b_vld_out"}, b_vld_out, m_bv);
        check({tag, ".a_last_out"}, a_last_out, m_al);
        $display("step %s: C_out=%h c_vld=%0b err=%0b busy=%0b", tag, C_out, c_vld, err, busy);
    endtask

    task automatic model_reset();
        m_sum = 0; m_in = 0; m_c = '0; m_cv = 0; m_err = 0;
        m_aout = '0; m_bout = '0; m_av = 0; m_bv = 0; m_al = 0;
    endtask

    // Apply the current inputs to the model, clock once, and compare.
    task automatic tick(input string tag);
        logic [16:0] f;
        bit          wr;
        wr = 0;
        f  = '0;
        if (en) begin
            m_aout = A; m_bout = B; m_av = a_vld; m_bv = b_vld; m_al = a_last;
            if (clr) begin
                m_sum = 0; m_in = 0;
            end else if (a_vld && b_vld) begin
                m_sum = (m_in ? m_sum : 0) + longint'($signed(A)) * longint'($signed(B));
                m_sum = (m_sum <<< 24) >>> 24;
                if (a_last) begin
                    f = fmt(m_sum); wr = 1; m_in = 0;
                end else begin
                    m_in = 1;
                end
            end
            if (wr) begin
                m_c = f[15:0]; m_cv = 1;
                if (c_shift || f[16]) m_err = 1;
            end else if (c_shift) begin
                m_c = c_in; m_cv = c_vld_in;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input bit v, input bit last);
        A = a; B = b; a_vld = v; b_vld = v; a_last = last;
    endtask

    initial begin
        rst = 1; en = 1; clr = 0; A = '0; B = '0; a_vld = 0; b_vld = 0; a_last = 0;
        c_shift = 0; c_in = '0; c_vld_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;

        // Two-pair tile in Q8.8
        set_op(16'h0180, 16'h0200, 1, 0); tick("t1_p0");
        set_op(16'h0043, 16'h00CA, 1, 1); tick("t1_last");
        check("t1_result", C_out, 16'h0335);
        set_op(16'h0000, 16'h0000, 0, 0); tick("t1_idle");

        // Negative operand and forwarding
        set_op(16'hFF00, 16'h0200, 1, 1); tick("t2_neg");
        check("t2_result", C_out, 16'hFE00);
        check("t2_fwd", A_out, 16'hFF00);
        set_op(16'h0000, 16'h0000, 0, 0); tick("t2_idle");

        // Overflowing product
        set_op(16'h7F00, 16'h7F00, 1, 1); tick("t3_ovf");
`ifdef PE_SAT_EN
        check("t3_result", C_out, 16'h7FFF);
        check("t3_err", err, 1'b1);
`else
        check("t3_result", C_out, 16'h0100);
        check("t3_err", err, 1'b0);
`endif

        // Back-to-back tiles, no bubble
        set_op(16'h0180, 16'h0200, 1, 1); tick("t4_tileA");
        check("t4_resA", C_out, 16'h0300);
        set_op(16'h0100, 16'h0100, 1, 1); tick("t4_tileB");
        check("t4_resB", C_out, 16'h0100);

        // Enable low mid-tile freezes everything
        set_op(16'h0100, 16'h0100, 1, 0); tick("t5_start");
        en = 0;
        set_op(16'h7777, 16'h1111, 1, 1); tick("t5_hold0");
        set_op(16'h2222, 16'h3333, 1, 1); tick("t5_hold1");
        en = 1;
        set_op(16'h0100, 16'h0100, 1, 1); tick("t5_resume");
        check("t5_result", C_out, 16'h0200);
        set_op(16'h0000, 16'h0000, 0, 0); tick("t5_idle");

        // Only one valid: no MAC
        A = 16'h0100; B = 16'h0100; a_vld = 1; b_vld = 0; a_last = 1; tick("t6_half");

        // Drain shift, then shift colliding with result write
        set_op(16'h0000, 16'h0000, 0, 0);
        c_shift = 1; c_in = 16'h1234; c_vld_in = 1; tick("t7_shift");
        check("t7_drain", C_out, 16'h1234);
        set_op(16'h0200, 16'h0200, 1, 1); c_in = 16'hBEEF; tick("t7_collide");
        check("t7_keep", C_out, 16'h0400);
        check("t7_err", err, 1'b1);
        c_shift = 0; c_vld_in = 0;

        // Clear overriding a finishing MAC, then async reset mid-tile
        set_op(16'h0100, 16'h0300, 1, 0); tick("t8_start");
        clr = 1; set_op(16'h0500, 16'h0500, 1, 1); tick("t8_clr");
        check("t8_nowrite", C_out, 16'h0400);
        clr = 0;
        set_op(16'h0100, 16'h0100, 1, 0); tick("t8_acc");
        #2;
        rst = 1;
        #1;
        model_reset();
        check_all("t8_async_rst");
        @(posedge clk);
        #1;
        rst = 0;
        set_op(16'h0000, 16'h0000, 0, 0); tick("t8_post");

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ra = {{6{ra[9]}}, ra[9:0]};
            if ($urandom_range(0, 3) != 0) rb = {{6{rb[9]}}, rb[9:0]};
            A = ra; B = rb;
            en       = ($urandom_range(0, 9) != 0);
            a_vld    = ($urandom_range(0, 4) != 0);
            b_vld    = ($urandom_range(0, 4) != 0);
            a_last   = ($urandom_range(0, 3) == 0);
            clr      = ($urandom_range(0, 19) == 0);
            c_shift  = ($urandom_range(0, 9) == 0);
            c_in     = 16'($urandom);
            c_vld_in = 1'($urandom);
            tick($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
